// File: rtl/csi2_pkg.sv
// csi2_pkg: shared CSI-2 definitions (FSM states, sync byte, CRC constants, data types, CRC helper)
package csi2_pkg;
  typedef enum logic [3:0] {
    IDLE, LP01, LP00, HS_ZERO, SYNC, HEADER, PAYLOAD, CRC, TRAIL, EXIT
  } st_t;
  localparam logic [7:0]  SYNC_BYTE = 8'hB8;
  localparam logic [15:0] CRC_SEED  = 16'hFFFF;
  localparam logic [15:0] CRC_POLY  = 16'h8408;
  localparam logic [5:0]  FS        = 6'h00;
  localparam logic [5:0]  FE        = 6'h01;
  localparam logic [5:0]  RAW8      = 6'h2A;
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ b[i]) ? CRC_POLY : 16'h0000);
    return r;
  endfunction
endpackage

// File: rtl/mipi_transmitter_if.sv
// mipi_transmitter_if: packet request and payload stream between a packet source and the transmitter
//   pkt_start/pkt_vc/pkt_type/pkt_wc : packet request; data_in/data_valid/data_ready : payload stream
interface mipi_transmitter_if;
  logic        pkt_start;
  logic [1:0]  pkt_vc;
  logic [5:0]  pkt_type;
  logic [15:0] pkt_wc;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  modport master (output pkt_start, pkt_vc, pkt_type, pkt_wc, data_in, data_valid, input data_ready);
  modport slave  (input pkt_start, pkt_vc, pkt_type, pkt_wc, data_in, data_valid, output data_ready);
endinterface

// File: rtl/csi2_ecc.sv
// csi2_ecc: combinational CSI-2 packet header Hamming ECC
//   d : header[23:0] = {wc[15:8], wc[7:0], vc, type}; ecc : {2'b00, P5..P0}
module csi2_ecc (
  input  logic [23:0] d,
  output logic [7:0]  ecc
);
  assign ecc = {2'b00,
                ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
                ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
endmodule

// File: rtl/mipi_transmitter.sv
// mipi_transmitter: two-lane CSI-2 D-PHY packet transmitter (LP entry, HS burst, trail, LP exit)
//   sync_mipi_clk_2/reset : clock (one nibble per lane per cycle), sync active-high reset
//   s                     : packet request and payload stream (slave side)
//   lane0_q/lane1_q       : nibbles to the DDR output cells, bit0 sent first
//   hs_oe, lp_p, lp_n     : HS driver enable and per-lane LP levels
//   busy, done, err       : packet in progress, end-of-packet pulse, reject/underrun pulse
module mipi_transmitter
  import csi2_pkg::*;
#(
  parameter int T_LPX     = 4,
  parameter int T_PREPARE = 4,
  parameter int T_ZERO    = 8,
  parameter int T_TRAIL   = 4,
  parameter int T_EXIT    = 8
) (
  input  logic             sync_mipi_clk_2,
  input  logic             reset,
  mipi_transmitter_if.slave s,
  output logic [3:0]       lane0_q,
  output logic [3:0]       lane1_q,
  output logic             hs_oe,
  output logic [1:0]       lp_p,
  output logic [1:0]       lp_n,
  output logic             busy,
  output logic             done,
  output logic             err
);
  st_t         state, nxt;
  logic [15:0] cnt, wc, crc, pay, len, d;
  logic [5:0]  dt;
  logic [1:0]  vc;
  logic [7:0]  ecc, by0, by1;
  logic [3:0]  nxt0, nxt1;
  logic        last, req_bad;
  csi2_ecc u_ecc (.d({wc, vc, dt}), .ecc(ecc));
  assign s.data_ready = state == PAYLOAD && !cnt[0];
  assign busy = state != IDLE;
  assign done = state == EXIT && last;
  always_comb begin
    req_bad = s.pkt_type >= 6'h10 && (s.pkt_wc[0] || s.pkt_wc == 16'd0);
    len = state == LP01 ? 16'(T_LPX) : state == LP00 ? 16'(T_PREPARE) :
          state == HS_ZERO ? 16'(T_ZERO) : state == SYNC ? 16'd2 :
          state == HEADER ? 16'd4 : state == PAYLOAD ? wc :
          state == CRC ? 16'd2 : state == TRAIL ? 16'(T_TRAIL) : 16'(T_EXIT);
    last = cnt == len - 16'd1;
    nxt = state == LP01 ? LP00 : state == LP00 ? HS_ZERO : state == HS_ZERO ? SYNC :
          state == SYNC ? HEADER : state == HEADER ? (dt >= 6'h10 ? PAYLOAD : TRAIL) :
          state == PAYLOAD ? CRC : state == CRC ? TRAIL : state == TRAIL ? EXIT : IDLE;
    d = s.data_valid ? s.data_in : 16'h0000;
    by0 = state == SYNC ? SYNC_BYTE : state == HEADER ? (cnt[1] ? wc[15:8] : {vc, dt}) :
          state == PAYLOAD ? (cnt[0] ? pay[7:0] : d[7:0]) : state == CRC ? crc[7:0] : 8'h00;
    by1 = state == SYNC ? SYNC_BYTE : state == HEADER ? (cnt[1] ? ecc : wc[7:0]) :
          state == PAYLOAD ? (cnt[0] ? pay[15:8] : d[15:8]) : state == CRC ? crc[15:8] : 8'h00;
    // trail latches the inverse of the last HS bit on entry, then holds it
    nxt0 = state == TRAIL ? (cnt == 16'd0 ? {4{~lane0_q[3]}} : lane0_q) : (cnt[0] ? by0[7:4] : by0[3:0]);
    nxt1 = state == TRAIL ? (cnt == 16'd0 ? {4{~lane1_q[3]}} : lane1_q) : (cnt[0] ? by1[7:4] : by1[3:0]);
  end
  // line outputs are registered: they show the state of the previous cycle
  always_ff @(posedge sync_mipi_clk_2) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      crc     <= CRC_SEED;
      wc      <= '0;
      vc      <= '0;
      dt      <= '0;
      pay     <= '0;
      err     <= 1'b0;
      hs_oe   <= 1'b0;
      lp_p    <= 2'b11;
      lp_n    <= 2'b11;
      lane0_q <= '0;
      lane1_q <= '0;
    end else begin
      err     <= (state == IDLE && s.pkt_start && req_bad) || (s.data_ready && !s.data_valid);
      hs_oe   <= state inside {HS_ZERO, SYNC, HEADER, PAYLOAD, CRC, TRAIL};
      lp_p    <= state inside {IDLE, EXIT} ? 2'b11 : 2'b00;
      lp_n    <= state inside {IDLE, EXIT, LP01} ? 2'b11 : 2'b00;
      lane0_q <= nxt0;
      lane1_q <= nxt1;
      if (state == IDLE) begin
        cnt <= '0;
        if (s.pkt_start && !req_bad) begin
          state <= LP01;
          vc    <= s.pkt_vc;
          dt    <= s.pkt_type;
          wc    <= s.pkt_wc;
          crc   <= CRC_SEED;
        end
      end else if (last) begin
        state <= nxt;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
      if (s.data_ready) begin
        pay <= d;
        crc <= crc16_byte(crc16_byte(crc, d[7:0]), d[15:8]);
      end
    end
  end
endmodule
